// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU: opcodes, controller phases,
// controller state and the strobe bundle driven into the datapath.
package cpu_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // HALTED is the phase counter frozen at OP_ADDR with the halted flag set.
  typedef struct packed {
    logic   halted;
    phase_t phase;
  } ctrl_state_t;

  localparam ctrl_state_t RESET_STATE  = '{halted: 1'b0, phase: INST_ADDR};
  localparam ctrl_state_t HALTED_STATE = '{halted: 1'b1, phase: OP_ADDR};

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
    logic halt;
  } strobes_t;

  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Instruction sequencer: walks the 8-phase instruction cycle and decodes
// state plus opcode into the datapath control strobes.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       is_zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic       halt,
  output logic [2:0] phase
);

  // Protocol: the controller is the initiator. opcode must be stable from
  // OP_ADDR through STORE; ld_ac is a single-cycle strobe in STORE and the
  // accumulator captures on the edge that ends it. There is no back-pressure.

  opcode_t     op;
  ctrl_state_t state_q;
  ctrl_state_t state_d;
  strobes_t    s;
  logic        aluop;

  assign op    = opcode_t'(opcode);
  assign aluop = is_aluop(op);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!state_q.halted) begin
      if ((state_q.phase == OP_ADDR) && (op == HLT)) begin
        state_d = HALTED_STATE;
      end else begin
        state_d.phase = phase_t'(state_q.phase + 3'd1);
      end
    end
  end

  always_comb begin
    s = '0;
    if (state_q.halted) begin
      s.halt = 1'b1;
    end else begin
      unique case (state_q.phase)
        INST_ADDR: begin
          s.sel = 1'b1;
        end
        INST_FETCH: begin
          s.sel = 1'b1;
          s.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          s.sel   = 1'b1;
          s.rd    = 1'b1;
          s.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          s.inc_pc = 1'b1;
        end
        OP_FETCH: begin
          s.rd = aluop;
        end
        ALU_OP: begin
          // The extra increment here is what makes SKZ skip the next word.
          s.rd     = aluop;
          s.inc_pc = (op == SKZ) && is_zero;
          s.ld_pc  = (op == JMP);
          s.data_e = (op == STO);
        end
        STORE: begin
          s.rd     = aluop;
          s.ld_ac  = aluop;
          s.inc_pc = (op == JMP);
          s.ld_pc  = (op == JMP);
          s.data_e = (op == STO);
          s.wr     = (op == STO);
        end
        default: begin
          s = '0;
        end
      endcase
    end
  end

  assign sel    = s.sel;
  assign rd     = s.rd;
  assign ld_ir  = s.ld_ir;
  assign inc_pc = s.inc_pc;
  assign ld_pc  = s.ld_pc;
  assign data_e = s.data_e;
  assign ld_ac  = s.ld_ac;
  assign wr     = s.wr;
  assign halt   = s.halt;
  assign phase  = state_q.phase;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller with a small ALU/accumulator model that
// captures on each sampled ld_ac pulse.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       is_zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt;
  logic [2:0] phase;

  logic [8:0] strobes;
  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt};

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] acc;
  logic [7:0] inb;
  int         pulses;
  int         seen_ld_ac;

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,data_e,ld_ac,wr,halt}
  localparam logic [8:0] V_P0   = 9'b100000000;
  localparam logic [8:0] V_P1   = 9'b110000000;
  localparam logic [8:0] V_P23  = 9'b111000000;
  localparam logic [8:0] V_P4   = 9'b000100000;
  localparam logic [8:0] V_NONE = 9'b000000000;
  localparam logic [8:0] V_RD   = 9'b010000000;
  localparam logic [8:0] V_RDAC = 9'b010000100;
  localparam logic [8:0] V_INC  = 9'b000100000;
  localparam logic [8:0] V_DE   = 9'b000001000;
  localparam logic [8:0] V_DEWR = 9'b000001010;
  localparam logic [8:0] V_LDPC = 9'b000010000;
  localparam logic [8:0] V_JMP7 = 9'b000110000;
  localparam logic [8:0] V_HALT = 9'b000000001;

  cpu_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .is_zero(is_zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .halt   (halt),
    .phase  (phase)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    n_checks++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed phase/strobes %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b010:  return a + b;
      3'b011:  return a & b;
      3'b100:  return a ^ b;
      3'b101:  return b;
      default: return a;
    endcase
  endfunction

  // Runs one full instruction starting at a sampled phase 0, ending at the next phase 0.
  task automatic run_instr(input string name, input logic [2:0] op, input logic iz,
                           input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] exp_v [8];
    exp_v = '{V_P0, V_P1, V_P23, V_P23, V_P4, e5, e6, e7};
    opcode  = op;
    is_zero = iz;
    pulses  = 0;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("%s_p%0d", name, p), {phase, strobes}, {3'(p), exp_v[p]});
      if (ld_ac) begin
        pulses++;
        acc = alu(op, acc, inb);
      end
      step();
    end
  endtask

  initial begin
    rst     = 1'b1;
    opcode  = 3'b000;
    is_zero = 1'b0;
    acc     = 8'd0;
    inb     = 8'd0;

    step();
    step();
    chk("reset_held", {phase, strobes}, {3'd0, V_P0});
    rst = 1'b0;

    inb = 8'd42;
    run_instr("lda", 3'b101, 1'b0, V_RD, V_RD, V_RDAC);
    chk_int("lda_pulses", pulses, 1);
    chk_int("lda_acc", int'(acc), 42);

    inb = 8'd25;
    run_instr("add", 3'b010, 1'b0, V_RD, V_RD, V_RDAC);
    chk_int("add_pulses", pulses, 1);
    chk_int("add_acc", int'(acc), 67);

    inb = 8'd7;
    run_instr("xor", 3'b100, 1'b1, V_RD, V_RD, V_RDAC);
    chk_int("xor_pulses", pulses, 1);
    chk_int("xor_acc", int'(acc), 68);

    run_instr("skz_z1", 3'b001, 1'b1, V_NONE, V_INC, V_NONE);
    run_instr("skz_z0", 3'b001, 1'b0, V_NONE, V_NONE, V_NONE);
    run_instr("sto", 3'b110, 1'b1, V_NONE, V_DE, V_DEWR);
    chk_int("sto_pulses", pulses, 0);
    run_instr("jmp", 3'b111, 1'b0, V_NONE, V_LDPC, V_JMP7);

    // HLT: phases 0..4 then HALTED on the 5th edge
    opcode = 3'b000;
    chk("hlt_p0", {phase, strobes}, {3'd0, V_P0});
    step();
    chk("hlt_p1", {phase, strobes}, {3'd1, V_P1});
    step();
    chk("hlt_p2", {phase, strobes}, {3'd2, V_P23});
    step();
    chk("hlt_p3", {phase, strobes}, {3'd3, V_P23});
    step();
    chk("hlt_p4", {phase, strobes}, {3'd4, V_P4});
    step();
    chk("hlt_enter", {phase, strobes}, {3'd4, V_HALT});
    for (int i = 0; i < 20; i++) begin
      opcode  = 3'($urandom_range(0, 7));
      is_zero = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("hlt_hold%0d", i), {phase, strobes}, {3'd4, V_HALT});
    end

    rst = 1'b1;
    step();
    chk("hlt_reset", {phase, strobes}, {3'd0, V_P0});
    rst = 1'b0;
    step();
    chk("hlt_reset_run", {phase, strobes}, {3'd1, V_P1});

    // Reset during ALU_OP of an ADD
    rst = 1'b1;
    step();
    rst = 1'b0;
    opcode = 3'b010;
    seen_ld_ac = 0;
    for (int p = 0; p < 6; p++) begin
      if (ld_ac) seen_ld_ac++;
      step();
    end
    chk("mid_p6", {phase, strobes}, {3'd6, V_RD});
    rst = 1'b1;
    step();
    if (ld_ac) seen_ld_ac++;
    chk("mid_reset", {phase, strobes}, {3'd0, V_P0});
    chk_int("mid_no_ld_ac", seen_ld_ac, 0);
    rst = 1'b0;
    step();
    chk("mid_restart", {phase, strobes}, {3'd1, V_P1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
